// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of a small combinational ALU interface.
//
// Accepts one command at a time over a valid/ready port and registers the operands and
// opcode onto the ALU inputs. It holds them for a settle window and then samples the ALU
// result. The response carries the sampled result, a golden-model expected value and a
// mismatch flag. Saturating counters track completed legal ops and mismatching ops.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/a/b/opcode command input (opcode: 000 add, 001 sub, 010 and, 011 or,
//                              100 xor, 111 clear; 101/110 illegal)
//   alu_a/b/opcode             registered drive into the ALU
//   alu_result                 ALU output
//   rsp_valid/ready            response handshake
//   rsp_result/expected        sampled and golden results
//   rsp_mismatch/illegal       response status
//   op_count/err_count         saturating op and error counters
module alu_op_sequencer #(
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [2:0]        cmd_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_expected,
  output logic              rsp_mismatch,
  output logic              rsp_illegal,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count
);

  // A settle window of zero behaves as one cycle.
  localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned SetW      = $clog2(SettleEff + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e              state_q, state_d;
  logic [SetW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   res_q, res_d, exp_q, exp_d;
  logic                mism_q, mism_d, ill_q, ill_d;
  logic [CNT_W-1:0]    opc_q, opc_d, errc_q, errc_d;
  logic [DATA_W-1:0]   golden;
  logic                cmd_illegal;

  assign cmd_illegal = (cmd_opcode == 3'b101) || (cmd_opcode == 3'b110);

  always_comb begin
    golden = '0;
    case (cmd_opcode)
      3'b000:  golden = cmd_a + cmd_b;
      3'b001:  golden = cmd_a - cmd_b;
      3'b010:  golden = cmd_a & cmd_b;
      3'b011:  golden = cmd_a | cmd_b;
      3'b100:  golden = cmd_a ^ cmd_b;
      default: golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b111;
      res_q    <= '0;
      exp_q    <= '0;
      mism_q   <= 1'b0;
      ill_q    <= 1'b0;
      opc_q    <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      exp_q    <= exp_d;
      mism_q   <= mism_d;
      ill_q    <= ill_d;
      opc_q    <= opc_d;
      errc_q   <= errc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    exp_d    = exp_q;
    mism_d   = mism_q;
    ill_d    = ill_q;
    opc_d    = opc_q;
    errc_d   = errc_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          mism_d = 1'b0;
          if (cmd_illegal) begin
            // ALU ports keep their previous value for an illegal opcode.
            ill_d   = 1'b1;
            res_d   = '0;
            exp_d   = '0;
            state_d = StResp;
          end else begin
            ill_d    = 1'b0;
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_opcode;
            exp_d    = golden;
            // Counter counts the settle cycles down; the result is sampled on the edge
            // after it reaches zero, so rsp_valid rises SettleEff+1 edges after accept.
            cnt_d    = SetW'(SettleEff);
            state_d  = StDrive;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          mism_d  = (alu_result != exp_q);
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - SetW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          if (!ill_q && (opc_q != '1)) opc_d = opc_q + CNT_W'(1);
          if (mism_q && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_result   = res_q;
  assign rsp_expected = exp_q;
  assign rsp_mismatch = mism_q;
  assign rsp_illegal  = ill_q;
  assign op_count     = opc_q;
  assign err_count    = errc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: the driver pushes expected responses, a monitor
// pops and compares on each response handshake. The ALU is modelled here with fault injection.
module tb_alu_op_sequencer;
  localparam int SC = 1;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_opcode = '0;
  logic       cmd_ready, rsp_valid, rsp_mismatch, rsp_illegal;
  logic [3:0] alu_a, alu_b, alu_result, rsp_result, rsp_expected;
  logic [2:0] alu_opcode;
  logic [7:0] op_count, err_count;
  logic       fault = 1'b0, hold = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  alu_op_sequencer #(.DATA_W(4), .SETTLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_expected(rsp_expected),
    .rsp_mismatch(rsp_mismatch), .rsp_illegal(rsp_illegal), .op_count(op_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic on plain integers, reduced modulo 16.
  function automatic logic [3:0] gold(input logic [3:0] a, input logic [3:0] b,
                                      input logic [2:0] op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = ia + ib;
      3'd1:    r = ia - ib + 16;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  assign alu_result = fault ? 4'h0 : gold(alu_a, alu_b, alu_opcode);

  always @(posedge clk) begin
    #2;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [3:0] res, expv, pa, pb;
    logic [2:0] po;
    logic       mism, ill;
    int         ops, errs, acc, lat;
  } exp_t;

  exp_t       q[$];
  int         m_op = 0, m_err = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [2:0] m_o = 3'b111;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: latency on first valid cycle, stability while stalled, compare on handshake.
  bit         seen = 0;
  logic [9:0] prev;
  exp_t       cur;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (rsp_valid) begin
      if (!seen) begin
        if (q.size() == 0) check("unexpected_rsp", 1, 0);
        else check("rsp_latency", cyc - q[0].acc, q[0].lat);
        seen = 1;
      end else begin
        check("rsp_stable", int'({rsp_result, rsp_expected, rsp_mismatch, rsp_illegal}),
              int'(prev));
      end
      prev = {rsp_result, rsp_expected, rsp_mismatch, rsp_illegal};
      check("cmd_ready_in_resp", int'(cmd_ready), 0);
      if (rsp_ready && q.size() > 0) begin
        cur = q.pop_front();
        check("rsp_result", int'(rsp_result), int'(cur.res));
        check("rsp_expected", int'(rsp_expected), int'(cur.expv));
        check("rsp_mismatch", int'(rsp_mismatch), int'(cur.mism));
        check("rsp_illegal", int'(rsp_illegal), int'(cur.ill));
        check("op_count", int'(op_count), cur.ops);
        check("err_count", int'(err_count), cur.errs);
        check("alu_ports", int'({alu_a, alu_b, alu_opcode}), int'({cur.pa, cur.pb, cur.po}));
        seen = 0;
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic f);
    int   w = 0;
    exp_t e;
    logic legal;
    @(negedge clk);
    while (!cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 0, 1);
      return;
    end
    fault = f;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    legal  = (op != 3'd5) && (op != 3'd6);
    e.expv = legal ? gold(a, b, op) : 4'h0;
    e.res  = legal ? (f ? 4'h0 : e.expv) : 4'h0;
    e.mism = legal && (e.res != e.expv);
    e.ill  = !legal;
    e.ops  = m_op;
    e.errs = m_err;
    if (legal) begin
      m_a = a; m_b = b; m_o = op;
    end
    e.pa = m_a; e.pb = m_b; e.po = m_o;
    e.acc = cyc;
    e.lat = legal ? SC + 1 : 0;
    q.push_back(e);
    if (legal && m_op < 255) m_op++;
    if (e.mism && m_err < 255) m_err++;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_alu_ports"}, int'({alu_a, alu_b, alu_opcode}), 7);
    check({tag, "_rsp_fields"},
          int'({rsp_result, rsp_expected, rsp_mismatch, rsp_illegal}), 0);
    check({tag, "_counts"}, int'({op_count, err_count}), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed: add, sub wrap, and/or/xor, clear.
    send(4'b0101, 4'b0011, 3'b000, 1'b0);
    send(4'b0011, 4'b0101, 3'b001, 1'b0);
    send(4'b1100, 4'b1010, 3'b010, 1'b0);
    send(4'b1100, 4'b1010, 3'b011, 1'b0);
    send(4'b1100, 4'b1010, 3'b100, 1'b0);
    send(4'b1100, 4'b1010, 3'b111, 1'b0);
    drain();

    // Backpressure: response held, junk commands must be ignored.
    hold = 1'b1;
    send(4'b0111, 4'b0110, 3'b000, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_opcode = 3'b000;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Illegal opcodes leave ALU ports and counters alone.
    send(4'b1111, 4'b0001, 3'b101, 1'b0);
    send(4'b0010, 4'b0001, 3'b110, 1'b0);
    drain();

    // Reset while in DRIVE.
    send(4'b1001, 4'b0110, 3'b000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("mid_reset");
    rst = 1'b0;
    q.delete();
    m_op = 0; m_err = 0; m_a = '0; m_b = '0; m_o = 3'b111;

    // Stuck-at-zero ALU: single error, then saturation.
    send(4'b0101, 4'b0011, 3'b000, 1'b1);
    drain();
    check("err_count_one", int'(err_count), 1);
    for (int i = 0; i < 259; i++) send(4'b0101, 4'b0011, 3'b000, 1'b1);
    drain();
    check("err_count_sat", int'(err_count), 255);
    check("op_count_sat", int'(op_count), 255);

    // Randomized traffic with occasional faults.
    for (int i = 0; i < 150; i++)
      send(4'($urandom), 4'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
    drain();
    check("final_op_count", int'(op_count), m_op);
    check("final_err_count", int'(err_count), m_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
